// File: rtl/mlp_engine.sv
// Two-layer dense inference engine (Dense -> ReLU -> Dense) built around one shared signed MAC.
// Build option: define MLP_SAT_EN to saturate outputs to OUT_W instead of two's-complement wrap.
module mlp_engine #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 5,
    parameter int ACC_W = 17,
    parameter int OUT_W = 12,
    parameter int AW    = $clog2(N_IN*N_HID + N_HID*N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*DW-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*OUT_W-1:0] out_data,
    output logic                   busy
);

    localparam int NW = N_IN*N_HID + N_HID*N_OUT;
    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] LAST_I  = IW'(N_IN - 1);
    localparam logic [HW-1:0] LAST_J  = HW'(N_HID - 1);
    localparam logic [OW-1:0] LAST_K  = OW'(N_OUT - 1);
    localparam logic [AW-1:0] W2_BASE = AW'(N_IN*N_HID);

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    state_t                    state;
    logic signed [DW-1:0]      wmem  [NW];
    logic signed [DW-1:0]      x     [N_IN];
    logic signed [ACC_W-1:0]   h     [N_HID];
    logic signed [OUT_W-1:0]   out_r [N_OUT];
    logic signed [ACC_W-1:0]   acc;
    logic [IW-1:0]             cnt_i;
    logic [HW-1:0]             cnt_j;
    logic [OW-1:0]             cnt_k;

    logic [AW-1:0]             w_addr;
    logic signed [DW-1:0]      op_w;
    logic signed [ACC_W-1:0]   op_a;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   acc_next;

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
        return a[ACC_W-1] ? '0 : a;
    endfunction

`ifdef MLP_SAT_EN
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] fit(input logic signed [ACC_W-1:0] a);
        if (a > ACC_W'(OUT_MAX))
            return OUT_MAX;
        else if (a < ACC_W'(OUT_MIN))
            return OUT_MIN;
        else
            return a[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] fit(input logic signed [ACC_W-1:0] a);
        return a[OUT_W-1:0];
    endfunction
`endif

    // Shared MAC: layer 1 walks x[i]*w1[i][j], layer 2 walks h[j]*w2[j][k]; products wrap in ACC_W.
    always_comb begin
        w_addr   = '0;
        op_a     = '0;
        if (state == L2) begin
            w_addr = W2_BASE + AW'(cnt_j) * AW'(N_OUT) + AW'(cnt_k);
            op_a   = h[cnt_j];
        end else begin
            w_addr = AW'(cnt_i) * AW'(N_HID) + AW'(cnt_j);
            op_a   = ACC_W'(x[cnt_i]);
        end
        op_w     = wmem[w_addr];
        prod     = op_a * ACC_W'(op_w);
        acc_next = acc + prod;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_data[g*OUT_W +: OUT_W] = out_r[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            cnt_i     <= '0;
            cnt_j     <= '0;
            cnt_k     <= '0;
            for (int n = 0; n < NW; n++)    wmem[n]  <= '0;
            for (int n = 0; n < N_IN; n++)  x[n]     <= '0;
            for (int n = 0; n < N_HID; n++) h[n]     <= '0;
            for (int n = 0; n < N_OUT; n++) out_r[n] <= '0;
        end else begin
            if (wr_en && state == IDLE && int'(wr_addr) < NW)
                wmem[wr_addr] <= wr_data;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int n = 0; n < N_IN; n++)
                            x[n] <= in_data[n*DW +: DW];
                        acc      <= '0;
                        cnt_i    <= '0;
                        cnt_j    <= '0;
                        cnt_k    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= L1;
                    end
                end
                L1: begin
                    if (cnt_i == LAST_I) begin
                        h[cnt_j] <= relu(acc_next);
                        acc      <= '0;
                        cnt_i    <= '0;
                        if (cnt_j == LAST_J) begin
                            cnt_j <= '0;
                            state <= L2;
                        end else begin
                            cnt_j <= cnt_j + 1'b1;
                        end
                    end else begin
                        acc   <= acc_next;
                        cnt_i <= cnt_i + 1'b1;
                    end
                end
                L2: begin
                    if (cnt_j == LAST_J) begin
                        out_r[cnt_k] <= fit(acc_next);
                        acc          <= '0;
                        cnt_j        <= '0;
                        if (cnt_k == LAST_K) begin
                            cnt_k     <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt_k <= cnt_k + 1'b1;
                        end
                    end else begin
                        acc   <= acc_next;
                        cnt_j <= cnt_j + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_engine.sv
// Directed bench for mlp_engine: hand-computed vectors through load, run, stall, drop and reset cases.
module tb_mlp_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [4:0]  wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lat;

`ifdef MLP_SAT_EN
    localparam int T3_EXP = 2047;
`else
    localparam int T3_EXP = 0;
`endif

    mlp_engine dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] outk(input int k);
        logic [11:0] v;
        v = out_data[k*12 +: 12];
        return 64'($signed(v));
    endfunction

    function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
        logic [4:0] e0, e1, e2, e3;
        e0 = 5'(a); e1 = 5'(b); e2 = 5'(c); e3 = 5'(d);
        return {e3, e2, e1, e0};
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = 5'(d);
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic load_all(input int w1v, input int w2v);
        for (int a = 0; a < 16; a++) wr(a, w1v);
        for (int a = 16; a < 24; a++) wr(a, w2v);
    endtask

    task automatic start_vec(input logic [19:0] x);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 60 && !out_valid; n++) @(negedge clk);
        lat = cyc - acc_cyc;
        check({tag, "_latency"}, lat, 24);
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_vld_clr"}, out_valid, 0);
        check({tag, "_rdy_set"}, in_ready, 1);
    endtask

    task automatic run(input string tag, input logic [19:0] x, input int e0, input int e1);
        start_vec(x);
        wait_done(tag);
        check({tag, "_out0"}, outk(0), e0);
        check({tag, "_out1"}, outk(1), e1);
        accept(tag);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #22;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk) rst_n = 1'b1;

        // T1: all ones, with busy/in_ready during run and output hold after accept
        load_all(1, 1);
        start_vec(pack4(1, 2, 3, 4));
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 0);
        wait_done("t1");
        check("t1_out0", outk(0), 40);
        check("t1_out1", outk(1), 40);
        accept("t1");
        check("t1_busy_clr", busy, 0);
        check("t1_hold0", outk(0), 40);

        // T2: negative hidden values clipped by ReLU
        for (int a = 0; a < 16; a++) wr(a, -1);
        run("t2", pack4(1, 2, 3, 4), 0, 0);

        // T3: extreme magnitudes, wrap or saturate
        load_all(-16, 15);
        run("t3", pack4(-16, -16, -16, -16), T3_EXP, T3_EXP);

        // T7: identity layer 1, distinct layer-2 columns, one negative input through ReLU
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) wr(i*4 + j, (i == j) ? 1 : 0);
        for (int j = 0; j < 4; j++) begin
            wr(16 + j*2, j + 1);
            wr(16 + j*2 + 1, (j == 3) ? 1 : 0);
        end
        run("t7a", pack4(1, 2, 3, 4), 30, 4);
        run("t7b", pack4(-3, 2, 3, 4), 29, 4);

        // T4: output stall, input ignored while DONE
        load_all(1, 1);
        start_vec(pack4(1, 2, 3, 4));
        wait_done("t4");
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pack4(5, 5, 5, 5);
            @(negedge clk);
            check("t4_vld_hold", out_valid, 1);
            check("t4_rdy_low", in_ready, 0);
            check("t4_out0_hold", outk(0), 40);
        end
        in_valid = 1'b0;
        check("t4_out1_hold", outk(1), 40);
        accept("t4");

        // T5: write during L1 dropped, write in IDLE applied
        start_vec(pack4(1, 2, 3, 4));
        wr(0, 7);
        wait_done("t5a");
        check("t5a_out0", outk(0), 40);
        check("t5a_out1", outk(1), 40);
        accept("t5a");
        run("t5b", pack4(1, 2, 3, 4), 40, 40);
        wr(0, 7);
        run("t5c", pack4(1, 2, 3, 4), 46, 46);

        // T6: asynchronous reset in L2 clears everything, including weights
        start_vec(pack4(1, 2, 3, 4));
        for (int n = 0; n < 40 && (cyc - acc_cyc) < 20; n++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_vld", out_valid, 0);
        check("t6_rdy", in_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_data", out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        run("t6_zero_w", pack4(1, 2, 3, 4), 0, 0);
        load_all(1, 1);
        run("t6_reload", pack4(1, 2, 3, 4), 40, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
